// File: rtl/sprite_position_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_position_ctrl
//  Purpose  : Produces the top-left corner (hPos, vPos) of the movable square
//             drawn by the VGA overlay. The four direction buttons are
//             synchronized and debounced. The square moves STEP pixels per
//             frame on each pressed axis and is clamped so that it always
//             stays fully on screen. Frame timing comes from the rising edge
//             of screenEnd (clk25 domain), which is resynchronized to clk.
//  Ports    : clk        - 100 MHz system clock
//             reset      - asynchronous, active-low reset
//             screenEnd  - frame-boundary pulse from the timing generator
//             BTNU/D/L/R - raw, asynchronous direction buttons
//             hPos       - square left edge x  (0 .. SCREEN_W-SIZE)
//             vPos       - square top edge y   (0 .. SCREEN_H-SIZE)
//             frameTick  - one-clk pulse per screenEnd rising edge
//             btnState   - debounced buttons {U,D,L,R}
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_position_ctrl #(
   parameter int SCREEN_W        = 640,
   parameter int SCREEN_H        = 480,
   parameter int SIZE            = 51,
   parameter int STEP            = 1,
   parameter int H_INIT          = 100,
   parameter int V_INIT          = 200,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       screenEnd,
   input  logic       BTNU,
   input  logic       BTND,
   input  logic       BTNL,
   input  logic       BTNR,
   output logic [9:0] hPos,
   output logic [8:0] vPos,
   output logic       frameTick,
   output logic [3:0] btnState
);

   localparam int          c_CW      = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [c_CW-1:0] c_DB_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [10:0] c_H_MAX   = 11'(SCREEN_W - SIZE);
   localparam logic [10:0] c_V_MAX   = 11'(SCREEN_H - SIZE);
   localparam logic [10:0] c_STEP    = 11'(STEP);

   // ------------------------------------------------------------------
   // Two-flop synchronizers; only the second stage is used downstream.
   // r_se_prev is the edge-detect history for screenEnd.
   // ------------------------------------------------------------------
   logic [3:0] w_btn_raw;
   logic [3:0] r_btn_s1;
   logic [3:0] r_btn_s2;
   logic       r_se_s1;
   logic       r_se_s2;
   logic       r_se_prev;

   assign w_btn_raw = {BTNU, BTND, BTNL, BTNR};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_btn_s1  <= 4'b0000;
         r_btn_s2  <= 4'b0000;
         r_se_s1   <= 1'b0;
         r_se_s2   <= 1'b0;
         r_se_prev <= 1'b0;
         frameTick <= 1'b0;
      end else begin
         r_btn_s1  <= w_btn_raw;
         r_btn_s2  <= r_btn_s1;
         r_se_s1   <= screenEnd;
         r_se_s2   <= r_se_s1;
         r_se_prev <= r_se_s2;
         // Registered rising-edge detect: a long screenEnd gives one tick.
         frameTick <= r_se_s2 & ~r_se_prev;
      end
   end

   // ------------------------------------------------------------------
   // Per-button debounce. The counter only runs while the synchronized
   // input disagrees with the debounced state; any agreement clears it,
   // so only an uninterrupted run of DEBOUNCE_CYCLES flips the state.
   // ------------------------------------------------------------------
   logic [3:0] w_state;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_debounce
         logic [c_CW-1:0] r_cnt;
         logic            r_state;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_cnt   <= '0;
               r_state <= 1'b0;
            end else if (r_btn_s2[gi] == r_state) begin
               r_cnt   <= '0;
            end else if (r_cnt == c_DB_LAST) begin
               r_state <= ~r_state;
               r_cnt   <= '0;
            end else begin
               r_cnt   <= r_cnt + 1'b1;
            end
         end

         assign w_state[gi] = r_state;
      end
   endgenerate

   assign btnState = w_state;

   // ------------------------------------------------------------------
   // Next-position arithmetic in 11 bits. The decrement checks for
   // underflow explicitly and the increment saturates at the clamp, so
   // neither axis can ever wrap.
   // ------------------------------------------------------------------
   logic [10:0] w_h_ext, w_v_ext;
   logic [10:0] w_h_dec, w_h_sum, w_h_inc, w_h_next;
   logic [10:0] w_v_dec, w_v_sum, w_v_inc, w_v_next;

   always_comb begin
      w_h_ext = {1'b0, hPos};
      w_v_ext = {2'b00, vPos};

      w_h_dec = (w_h_ext < c_STEP) ? 11'd0 : (w_h_ext - c_STEP);
      w_h_sum = w_h_ext + c_STEP;
      w_h_inc = (w_h_sum > c_H_MAX) ? c_H_MAX : w_h_sum;

      w_v_dec = (w_v_ext < c_STEP) ? 11'd0 : (w_v_ext - c_STEP);
      w_v_sum = w_v_ext + c_STEP;
      w_v_inc = (w_v_sum > c_V_MAX) ? c_V_MAX : w_v_sum;

      // Opposing buttons on one axis cancel out.
      case (btnState[1:0])          // {L,R}
         2'b10:   w_h_next = w_h_dec;
         2'b01:   w_h_next = w_h_inc;
         default: w_h_next = w_h_ext;
      endcase

      case (btnState[3:2])          // {U,D}
         2'b10:   w_v_next = w_v_dec;
         2'b01:   w_v_next = w_v_inc;
         default: w_v_next = w_v_ext;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hPos <= 10'(H_INIT);
         vPos <= 9'(V_INIT);
      end else if (frameTick) begin
         hPos <= w_h_next[9:0];
         vPos <= w_v_next[8:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sprite_position_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_position_ctrl
//  Purpose  : Self-checking bench for sprite_position_ctrl. The stimulus
//             process pushes the hand-computed position expected after each
//             frame into a queue; a monitor pops and compares on every
//             frameTick it observes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_position_ctrl;

   logic       clk;
   logic       reset;
   logic       screenEnd;
   logic       BTNU, BTND, BTNL, BTNR;
   logic [9:0] hPos;
   logic [8:0] vPos;
   logic       frameTick;
   logic [3:0] btnState;

   int errors = 0;
   int checks = 0;

   logic [18:0] exp_q[$];

   sprite_position_ctrl #(
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .screenEnd (screenEnd),
      .BTNU      (BTNU),
      .BTND      (BTND),
      .BTNL      (BTNL),
      .BTNR      (BTNR),
      .hPos      (hPos),
      .vPos      (vPos),
      .frameTick (frameTick),
      .btnState  (btnState)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: each tick must be matched by a queued expectation, compared
   // right after the update edge.
   initial begin
      logic [18:0] e;
      forever begin
         @(negedge clk);
         if (frameTick === 1'b1) begin
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_tick: got h=%0d v=%0d, expected no tick", hPos, vPos);
            end else begin
               e = exp_q.pop_front();
               if ({hPos, vPos} !== e) begin
                  errors++;
                  $display("FAIL frame_pos: got h=%0d v=%0d, expected h=%0d v=%0d",
                           hPos, vPos, e[18:9], e[8:0]);
               end
            end
         end
      end
   end

   // One frame: screenEnd high 4 cycles; tick must appear once, 3 cycles
   // after the rising edge.
   task automatic frame(input int eh, input int ev);
      int seen, lat;
      exp_q.push_back({10'(eh), 9'(ev)});
      seen = 0;
      lat  = 0;
      @(posedge clk); #1 screenEnd = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (k == 4) screenEnd = 1'b0;
         if (frameTick) begin
            if (seen == 0) lat = k;
            seen++;
         end
      end
      check("tick_count", seen, 1);
      check("tick_latency", lat, 3);
      check("queue_drained", exp_q.size(), 0);
   endtask

   task automatic wait_btn(input string name, input logic [3:0] exp);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (btnState == exp) break;
      end
      check(name, int'(btnState), int'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int bad, lat;
      reset = 1'b0; screenEnd = 1'b0;
      BTNU = 0; BTND = 0; BTNL = 0; BTNR = 0;
      @(posedge clk); #1;
      check("rst_h", hPos, 100);
      check("rst_v", vPos, 200);
      check("rst_btn", btnState, 0);
      check("rst_tick", frameTick, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Activity, then asynchronous reset mid-cycle.
      BTNR = 1;
      wait_btn("pre_rst_btn", 4'b0001);
      @(posedge clk); #3 reset = 1'b0;
      #1;
      check("arst_h", hPos, 100);
      check("arst_v", vPos, 200);
      check("arst_btn", btnState, 0);
      check("arst_tick", frameTick, 0);
      BTNR = 0;
      @(posedge clk); #1 reset = 1'b1;

      // Ten idle frames: ten ticks, no movement.
      for (int i = 0; i < 10; i++) frame(100, 200);

      // Bounce on BTNR shorter than the debounce window.
      bad = 0;
      for (int t = 0; t < 8; t++) begin
         BTNR = ~BTNR;
         repeat (3) begin
            @(posedge clk); #1;
            if (btnState[0] !== 1'b0) bad++;
         end
      end
      check("bounce_ignored", bad, 0);
      // Stable press: 2 sync cycles + 8 debounce cycles.
      BTNR = 1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (btnState[0]) begin lat = k; break; end
      end
      check("debounce_latency", lat, 10);
      for (int h = 101; h <= 105; h++) frame(h, 200);
      BTNR = 0;
      wait_btn("r_release", 4'b0000);

      // Left clamp at 0.
      BTNL = 1;
      wait_btn("l_press", 4'b0010);
      for (int h = 104; h >= 2; h--) frame(h, 200);
      frame(1, 200);
      for (int i = 0; i < 4; i++) frame(0, 200);
      BTNL = 0;
      wait_btn("l_release", 4'b0000);

      // Bottom clamp at 429, then U+D cancel.
      BTND = 1;
      wait_btn("d_press", 4'b0100);
      for (int v = 201; v <= 427; v++) frame(0, v);
      frame(0, 428);
      for (int i = 0; i < 3; i++) frame(0, 429);
      BTNU = 1;
      wait_btn("ud_press", 4'b1100);
      for (int i = 0; i < 3; i++) frame(0, 429);
      BTNU = 0; BTND = 0;
      wait_btn("ud_release", 4'b0000);

      // Reset, then diagonal up-right.
      @(posedge clk); #2 reset = 1'b0;
      #1;
      check("arst2_h", hPos, 100);
      check("arst2_v", vPos, 200);
      @(posedge clk); #1 reset = 1'b1;
      BTNU = 1; BTNR = 1;
      wait_btn("ur_press", 4'b1001);
      for (int i = 1; i <= 10; i++) frame(100 + i, 200 - i);

      // Change between ticks: no movement until the next tick.
      BTNU = 0;
      wait_btn("u_release", 4'b0001);
      repeat (5) @(posedge clk);
      #1;
      check("hold_h", hPos, 110);
      check("hold_v", vPos, 190);
      frame(111, 190);

      repeat (5) @(posedge clk);
      check("final_queue", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
